rob: RTL and testbench
======================

ROB -- requirements
Module: rob

Interface
REQ-001 Parameter ROB_SIZE, default 16, number of entries (power of two); index width 4 bits (`ROB_IDX_WIDTH).
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst_in  in  1  reset; asynchronous, active-low.
REQ-004 rdy_in  in  1  global ready; low = stall.
REQ-005 de_in_en  in  1  decoder allocates one entry this cycle.
REQ-006 de_type_in  in  2  0=REG write, 1=BRANCH, 2=STORE.
REQ-007 de_rd_in  in  5  destination register (REG only).
REQ-008 de_ready_in / de_val_in  in  1/32  result already known at issue, and its value.
REQ-009 de_pred_taken_in  in  1  predictor decision (BRANCH only).
REQ-010 de_alt_pc_in  in  32  restart PC if prediction wrong.
REQ-011 rob_tail_idx_out  out  4  index the next allocation receives.
REQ-012 rob_full  out  1  no free entry.
REQ-013 rs_in_en / rs_rob_idx_in / rs_val_in  in  1/4/32  RS CDB broadcast.
REQ-014 lsb_in_en / lsb_rob_idx_in / lsb_val_in  in  1/4/32  LSB CDB broadcast.
REQ-015 qj_idx_in, qk_idx_in  in  4  operand lookup indices from decoder.
REQ-016 qj_ready_out, qk_ready_out  out  1; qj_val_out, qk_val_out  out  32  lookup results.
REQ-017 rf_commit_en / rf_commit_rd / rf_commit_val / rf_commit_rob_idx  out  1/5/32/4  register-file commit.
REQ-018 st_commit_en / st_commit_rob_idx  out  1/4  store release to LSB.
REQ-019 roll_back / rb_pc_out  out  1/32  misprediction flush and restart PC.

Function
REQ-020 Entries form a circular queue: head, tail (4-bit, wrap ROB_SIZE-1 -> 0), count (5-bit, 0..ROB_SIZE).
REQ-021 rob_full = (count == ROB_SIZE), combinational from registers; rob_tail_idx_out = tail.
REQ-022 Allocate: de_in_en && !rob_full && !roll_back writes entry[tail] (busy=1, ready=de_ready_in, fields), tail+1; de_in_en while full or while roll_back high is ignored.
REQ-023 Writeback: rs_in_en sets ready=1, value=rs_val_in on busy entry rs_rob_idx_in; same for LSB; both in one cycle to different entries both take effect; same index -> RS value wins; writeback to non-busy entry ignored.
REQ-024 Commit: at most one per cycle; at an edge where entry[head] busy && ready (registered ready bit), entry frees, head+1, count-1.
REQ-025 Consequence: result written at edge N commits no earlier than edge N+1; de_ready_in=1 allocation commits no earlier than next edge.
REQ-026 count_nxt = count + alloc - commit; simultaneous alloc and commit leave count unchanged.
REQ-027 REG commit: rf_commit_en pulses 1 cycle after the commit edge with rd, value, index (rd=0 still pulses).
REQ-028 STORE commit: st_commit_en pulses 1 cycle with index.
REQ-029 BRANCH commit: value[0] is actual taken; if it differs from pred_taken, roll_back pulses 1 cycle with rb_pc_out=alt_pc and, on the same edge, all entries clear, head=tail=0, count=0; correct branch commits silently.
REQ-030 Entries younger than a mispredicted branch never commit; no allocation or writeback accepted in the roll_back cycle.
REQ-031 Lookup (combinational): ready_out=1 if entry[idx] ready, or rs_in_en with matching index, or lsb_in_en with matching index; val_out from RS bypass, else LSB bypass, else stored value; 0 value when not ready.
REQ-032 rdy_in low: all state holds; all pulse outputs (rf_commit_en, st_commit_en, roll_back) registered 0.
REQ-033 Pulse outputs are registered; data outputs hold last value when enable low.

Reset
REQ-034 rst_in low asynchronously clears busy/ready bits, head, tail, count and all outputs to 0; rob_full=0 during and after reset.
REQ-035 Reset mid-operation discards all entries; no commit pulse emitted for them.

Verification
REQ-036 Allocate REG rd=5 idx0, RS writes idx0 val 0x1234 -> one cycle later rf_commit_en=1, rd=5, val=0x1234, idx=0.
REQ-037 Fill 16 entries -> rob_full=1, 17th de_in_en ignored; commit head -> rob_full=0 next cycle, tail wraps 15->0.
REQ-038 Out-of-order writeback idx2 then idx1 then idx0 -> commits in order 0,1,2 on consecutive cycles.
REQ-039 BRANCH pred_taken=1, RS returns 0, alt_pc=0x100, two younger REG entries ready -> roll_back pulse, rb_pc_out=0x100, no rf_commit for younger, count=0.
REQ-040 Lookup idx3 while rs_in_en idx3 val 0x55 same cycle -> qj_ready_out=1, qj_val_out=0x55; RS and LSB same index -> RS value stored.
REQ-041 rdy_in low two cycles with head ready -> no commit pulses, state unchanged; commit on first cycle rdy_in high.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: circular queue of ROB_SIZE entries with in-order commit,
// CDB writeback from RS and LSB, operand bypass lookup and branch-mispredict flush.
package rob_pkg;
    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_BRANCH = 2'd1,
        T_STORE  = 2'd2
    } rob_type_e;

    typedef struct packed {
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        pred_taken;
        logic [31:0] alt_pc;
    } rob_data_t;
endpackage

module rob_entry
    import rob_pkg::*;
(
    input  logic        clk,
    input  logic        rst_in,
    input  logic        flush,
    input  logic        alloc,
    input  logic        alloc_ready,
    input  rob_data_t   alloc_data,
    input  logic        wb_en,
    input  logic [31:0] wb_val,
    input  logic        free,
    output logic        busy,
    output logic        ready,
    output rob_data_t   data
);
    // Flush beats everything; alloc and free never target the same slot in one cycle.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            busy  <= 1'b0;
            ready <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            busy  <= 1'b0;
            ready <= 1'b0;
        end else if (alloc) begin
            busy  <= 1'b1;
            ready <= alloc_ready;
            data  <= alloc_data;
        end else if (free) begin
            busy  <= 1'b0;
            ready <= 1'b0;
        end else if (wb_en && busy) begin
            ready    <= 1'b1;
            data.val <= wb_val;
        end
    end
endmodule

module rob
    import rob_pkg::*;
#(
    parameter int ROB_SIZE = 16,
    localparam int IDX_W   = $clog2(ROB_SIZE),
    localparam int CNT_W   = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             de_in_en,
    input  logic [1:0]       de_type_in,
    input  logic [4:0]       de_rd_in,
    input  logic             de_ready_in,
    input  logic [31:0]      de_val_in,
    input  logic             de_pred_taken_in,
    input  logic [31:0]      de_alt_pc_in,
    output logic [IDX_W-1:0] rob_tail_idx_out,
    output logic             rob_full,
    input  logic             rs_in_en,
    input  logic [IDX_W-1:0] rs_rob_idx_in,
    input  logic [31:0]      rs_val_in,
    input  logic             lsb_in_en,
    input  logic [IDX_W-1:0] lsb_rob_idx_in,
    input  logic [31:0]      lsb_val_in,
    input  logic [IDX_W-1:0] qj_idx_in,
    input  logic [IDX_W-1:0] qk_idx_in,
    output logic             qj_ready_out,
    output logic             qk_ready_out,
    output logic [31:0]      qj_val_out,
    output logic [31:0]      qk_val_out,
    output logic             rf_commit_en,
    output logic [4:0]       rf_commit_rd,
    output logic [31:0]      rf_commit_val,
    output logic [IDX_W-1:0] rf_commit_rob_idx,
    output logic             st_commit_en,
    output logic [IDX_W-1:0] st_commit_rob_idx,
    output logic             roll_back,
    output logic [31:0]      rb_pc_out
);
    logic [IDX_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic [ROB_SIZE-1:0]            ent_busy, ent_ready, ent_alloc, ent_wb, ent_free;
    logic [ROB_SIZE-1:0][31:0]      ent_wb_val;
    rob_data_t                      ent_data [ROB_SIZE];

    rob_data_t de_data, head_data;
    logic      alloc, commit, wb_ok, mispredict;

    assign rob_full         = (count == CNT_W'(ROB_SIZE));
    assign rob_tail_idx_out = tail;

    assign de_data = '{typ: rob_type_e'(de_type_in), rd: de_rd_in, val: de_val_in,
                       pred_taken: de_pred_taken_in, alt_pc: de_alt_pc_in};

    // The cycle roll_back is high belongs to the restart; nothing from the old path lands.
    assign alloc      = rdy_in && de_in_en && !rob_full && !roll_back;
    assign wb_ok      = rdy_in && !roll_back;
    assign head_data  = ent_data[head];
    assign commit     = rdy_in && ent_busy[head] && ent_ready[head];
    assign mispredict = commit && head_data.typ == T_BRANCH &&
                        head_data.val[0] != head_data.pred_taken;

    for (genvar i = 0; i < ROB_SIZE; i++) begin : g_ent
        logic rs_hit, lsb_hit;
        assign rs_hit        = rs_in_en  && rs_rob_idx_in  == IDX_W'(i);
        assign lsb_hit       = lsb_in_en && lsb_rob_idx_in == IDX_W'(i);
        assign ent_alloc[i]  = alloc  && tail == IDX_W'(i);
        assign ent_free[i]   = commit && head == IDX_W'(i);
        assign ent_wb[i]     = wb_ok  && (rs_hit || lsb_hit);
        assign ent_wb_val[i] = rs_hit ? rs_val_in : lsb_val_in;

        rob_entry u_ent (
            .clk        (clk),
            .rst_in     (rst_in),
            .flush      (mispredict),
            .alloc      (ent_alloc[i]),
            .alloc_ready(de_ready_in),
            .alloc_data (de_data),
            .wb_en      (ent_wb[i]),
            .wb_val     (ent_wb_val[i]),
            .free       (ent_free[i]),
            .busy       (ent_busy[i]),
            .ready      (ent_ready[i]),
            .data       (ent_data[i])
        );
    end

    // Operand lookup with same-cycle CDB bypass; RS has priority over LSB.
    logic [1:0][IDX_W-1:0] q_idx;
    logic [1:0]            q_rdy;
    logic [1:0][31:0]      q_val;
    assign q_idx = {qk_idx_in, qj_idx_in};

    always_comb begin
        q_rdy = '0;
        q_val = '0;
        for (int k = 0; k < 2; k++) begin
            if (rs_in_en && rs_rob_idx_in == q_idx[k]) begin
                q_rdy[k] = 1'b1;
                q_val[k] = rs_val_in;
            end else if (lsb_in_en && lsb_rob_idx_in == q_idx[k]) begin
                q_rdy[k] = 1'b1;
                q_val[k] = lsb_val_in;
            end else if (ent_ready[q_idx[k]]) begin
                q_rdy[k] = 1'b1;
                q_val[k] = ent_data[q_idx[k]].val;
            end
        end
    end

    assign qj_ready_out = q_rdy[0];
    assign qk_ready_out = q_rdy[1];
    assign qj_val_out   = q_val[0];
    assign qk_val_out   = q_val[1];

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            rf_commit_en      <= 1'b0;
            rf_commit_rd      <= '0;
            rf_commit_val     <= '0;
            rf_commit_rob_idx <= '0;
            st_commit_en      <= 1'b0;
            st_commit_rob_idx <= '0;
            roll_back         <= 1'b0;
            rb_pc_out         <= '0;
        end else begin
            rf_commit_en <= 1'b0;
            st_commit_en <= 1'b0;
            roll_back    <= 1'b0;
            if (mispredict) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                roll_back <= 1'b1;
                rb_pc_out <= head_data.alt_pc;
            end else if (rdy_in) begin
                if (alloc)  tail <= tail + 1'b1;
                if (commit) head <= head + 1'b1;
                count <= count + CNT_W'(alloc) - CNT_W'(commit);
                if (commit && head_data.typ == T_REG) begin
                    rf_commit_en      <= 1'b1;
                    rf_commit_rd      <= head_data.rd;
                    rf_commit_val     <= head_data.val;
                    rf_commit_rob_idx <= head;
                end
                if (commit && head_data.typ == T_STORE) begin
                    st_commit_en      <= 1'b1;
                    st_commit_rob_idx <= head;
                end
            end
        end
    end
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: allocation, writeback, ordered commit, flush, stall, lookup.
module tb_rob;
    logic        clk, rst_in, rdy_in;
    logic        de_in_en, de_ready_in, de_pred_taken_in;
    logic [1:0]  de_type_in;
    logic [4:0]  de_rd_in;
    logic [31:0] de_val_in, de_alt_pc_in;
    logic [3:0]  rob_tail_idx_out;
    logic        rob_full;
    logic        rs_in_en, lsb_in_en;
    logic [3:0]  rs_rob_idx_in, lsb_rob_idx_in, qj_idx_in, qk_idx_in;
    logic [31:0] rs_val_in, lsb_val_in;
    logic        qj_ready_out, qk_ready_out;
    logic [31:0] qj_val_out, qk_val_out;
    logic        rf_commit_en, st_commit_en, roll_back;
    logic [4:0]  rf_commit_rd;
    logic [31:0] rf_commit_val, rb_pc_out;
    logic [3:0]  rf_commit_rob_idx, st_commit_rob_idx;

    int errors = 0;
    int checks = 0;

    rob dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .de_in_en(de_in_en), .de_type_in(de_type_in), .de_rd_in(de_rd_in),
        .de_ready_in(de_ready_in), .de_val_in(de_val_in),
        .de_pred_taken_in(de_pred_taken_in), .de_alt_pc_in(de_alt_pc_in),
        .rob_tail_idx_out(rob_tail_idx_out), .rob_full(rob_full),
        .rs_in_en(rs_in_en), .rs_rob_idx_in(rs_rob_idx_in), .rs_val_in(rs_val_in),
        .lsb_in_en(lsb_in_en), .lsb_rob_idx_in(lsb_rob_idx_in), .lsb_val_in(lsb_val_in),
        .qj_idx_in(qj_idx_in), .qk_idx_in(qk_idx_in),
        .qj_ready_out(qj_ready_out), .qk_ready_out(qk_ready_out),
        .qj_val_out(qj_val_out), .qk_val_out(qk_val_out),
        .rf_commit_en(rf_commit_en), .rf_commit_rd(rf_commit_rd),
        .rf_commit_val(rf_commit_val), .rf_commit_rob_idx(rf_commit_rob_idx),
        .st_commit_en(st_commit_en), .st_commit_rob_idx(st_commit_rob_idx),
        .roll_back(roll_back), .rb_pc_out(rb_pc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1'b1; de_in_en = 1'b0; de_type_in = 2'd0; de_rd_in = '0;
        de_ready_in = 1'b0; de_val_in = '0; de_pred_taken_in = 1'b0; de_alt_pc_in = '0;
        rs_in_en = 1'b0; rs_rob_idx_in = '0; rs_val_in = '0;
        lsb_in_en = 1'b0; lsb_rob_idx_in = '0; lsb_val_in = '0;
        qj_idx_in = '0; qk_idx_in = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
    endtask

    task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                         input logic [31:0] val, input logic pred, input logic [31:0] alt);
        de_in_en = 1'b1; de_type_in = t; de_rd_in = rd; de_ready_in = rdy;
        de_val_in = val; de_pred_taken_in = pred; de_alt_pc_in = alt;
        tick();
        de_in_en = 1'b0;
    endtask

    task automatic rs_wb(input logic [3:0] idx, input logic [31:0] val);
        rs_in_en = 1'b1; rs_rob_idx_in = idx; rs_val_in = val;
        tick();
        rs_in_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b0;
        #12;
        checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", rob_full); end
        checks++; if (rob_tail_idx_out !== 4'd0) begin errors++; $display("FAIL reset_tail got=%0d exp=0", rob_tail_idx_out); end
        checks++; if ({rf_commit_en, st_commit_en, roll_back} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {rf_commit_en, st_commit_en, roll_back}); end
        checks++; if (rb_pc_out !== 32'd0) begin errors++; $display("FAIL reset_rbpc got=%h exp=0", rb_pc_out); end
        tick();
        rst_in = 1'b1;
    endtask

    task automatic test_basic_commit();
        do_reset();
        alloc(2'd0, 5'd5, 1'b0, 32'd0, 1'b0, 32'd0);
        checks++; if (rob_tail_idx_out !== 4'd1) begin errors++; $display("FAIL basic_tail got=%0d exp=1", rob_tail_idx_out); end
        rs_wb(4'd0, 32'h1234);
        checks++; if (rf_commit_en !== 1'b0) begin errors++; $display("FAIL basic_early got=%b exp=0", rf_commit_en); end
        tick();
        checks++; if ({rf_commit_en, rf_commit_rd, rf_commit_val, rf_commit_rob_idx} !== {1'b1, 5'd5, 32'h1234, 4'd0})
            begin errors++; $display("FAIL basic_commit got=%b/%0d/%h/%0d exp=1/5/1234/0", rf_commit_en, rf_commit_rd, rf_commit_val, rf_commit_rob_idx); end
        tick();
        checks++; if (rf_commit_en !== 1'b0) begin errors++; $display("FAIL basic_pulse got=%b exp=0", rf_commit_en); end
        checks++; if (rf_commit_val !== 32'h1234) begin errors++; $display("FAIL basic_hold got=%h exp=1234", rf_commit_val); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) alloc(2'd0, 5'(i), 1'b0, 32'd0, 1'b0, 32'd0);
        checks++; if ({rob_full, rob_tail_idx_out} !== {1'b1, 4'd0}) begin errors++; $display("FAIL full_set got=%b/%0d exp=1/0", rob_full, rob_tail_idx_out); end
        alloc(2'd0, 5'd20, 1'b1, 32'd0, 1'b0, 32'd0);
        checks++; if ({rob_full, rob_tail_idx_out} !== {1'b1, 4'd0}) begin errors++; $display("FAIL full_ignore got=%b/%0d exp=1/0", rob_full, rob_tail_idx_out); end
        rs_wb(4'd0, 32'hF0);
        tick();
        checks++; if ({rf_commit_en, rf_commit_rd, rf_commit_val} !== {1'b1, 5'd0, 32'hF0}) begin errors++; $display("FAIL full_commit got=%b/%0d/%h exp=1/0/f0", rf_commit_en, rf_commit_rd, rf_commit_val); end
        checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL full_clear got=%b exp=0", rob_full); end
        alloc(2'd0, 5'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        checks++; if ({rob_full, rob_tail_idx_out} !== {1'b1, 4'd1}) begin errors++; $display("FAIL full_refill got=%b/%0d exp=1/1", rob_full, rob_tail_idx_out); end
    endtask

    task automatic test_ooo();
        logic [3:0]  exp_idx [3];
        logic [31:0] exp_val [3];
        exp_idx = '{4'd0, 4'd1, 4'd2};
        exp_val = '{32'h10, 32'h11, 32'h22};
        do_reset();
        for (int i = 0; i < 3; i++) alloc(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
        rs_wb(4'd2, 32'h22);
        checks++; if (rf_commit_en !== 1'b0) begin errors++; $display("FAIL ooo_early got=%b exp=0", rf_commit_en); end
        rs_wb(4'd1, 32'h11);
        rs_wb(4'd0, 32'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rf_commit_en, rf_commit_rob_idx, rf_commit_val} !== {1'b1, exp_idx[i], exp_val[i]}) begin
                errors++;
                $display("FAIL ooo_commit%0d got=%b/%0d/%h exp=1/%0d/%h", i, rf_commit_en, rf_commit_rob_idx, rf_commit_val, exp_idx[i], exp_val[i]);
            end
        end
    endtask

    task automatic test_store();
        do_reset();
        alloc(2'd0, 5'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        alloc(2'd2, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        rs_wb(4'd0, 32'h5);
        tick();
        tick();
        checks++; if ({st_commit_en, st_commit_rob_idx, rf_commit_en} !== {1'b1, 4'd1, 1'b0}) begin errors++; $display("FAIL store_commit got=%b/%0d/%b exp=1/1/0", st_commit_en, st_commit_rob_idx, rf_commit_en); end
        tick();
        checks++; if (st_commit_en !== 1'b0) begin errors++; $display("FAIL store_pulse got=%b exp=0", st_commit_en); end
    endtask

    task automatic test_lookup_collision();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(2'd0, 5'(i), 1'b0, 32'd0, 1'b0, 32'd0);
        qj_idx_in = 4'd3; qk_idx_in = 4'd2;
        rs_in_en = 1'b1; rs_rob_idx_in = 4'd3; rs_val_in = 32'h55;
        #1;
        checks++; if ({qj_ready_out, qj_val_out} !== {1'b1, 32'h55}) begin errors++; $display("FAIL lookup_bypass got=%b/%h exp=1/55", qj_ready_out, qj_val_out); end
        checks++; if ({qk_ready_out, qk_val_out} !== {1'b0, 32'h0}) begin errors++; $display("FAIL lookup_notready got=%b/%h exp=0/0", qk_ready_out, qk_val_out); end
        tick();
        rs_in_en = 1'b0;
        #1;
        checks++; if ({qj_ready_out, qj_val_out} !== {1'b1, 32'h55}) begin errors++; $display("FAIL lookup_stored got=%b/%h exp=1/55", qj_ready_out, qj_val_out); end
        // RS and LSB hit idx0 together; LSB alone hits idx1 next cycle
        qj_idx_in = 4'd0;
        rs_in_en = 1'b1; rs_rob_idx_in = 4'd0; rs_val_in = 32'hAA;
        lsb_in_en = 1'b1; lsb_rob_idx_in = 4'd0; lsb_val_in = 32'hBB;
        #1;
        checks++; if ({qj_ready_out, qj_val_out} !== {1'b1, 32'hAA}) begin errors++; $display("FAIL lookup_prio got=%b/%h exp=1/aa", qj_ready_out, qj_val_out); end
        tick();
        rs_in_en = 1'b0; lsb_rob_idx_in = 4'd1; lsb_val_in = 32'hCC;
        tick();
        lsb_in_en = 1'b0;
        checks++; if ({rf_commit_en, rf_commit_rob_idx, rf_commit_val} !== {1'b1, 4'd0, 32'hAA}) begin errors++; $display("FAIL collide_rs got=%b/%0d/%h exp=1/0/aa", rf_commit_en, rf_commit_rob_idx, rf_commit_val); end
        tick();
        checks++; if ({rf_commit_en, rf_commit_rob_idx, rf_commit_val} !== {1'b1, 4'd1, 32'hCC}) begin errors++; $display("FAIL lsb_wb got=%b/%0d/%h exp=1/1/cc", rf_commit_en, rf_commit_rob_idx, rf_commit_val); end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc(2'd1, 5'd0, 1'b0, 32'd0, 1'b1, 32'h100);
        alloc(2'd0, 5'd1, 1'b1, 32'd7, 1'b0, 32'd0);
        alloc(2'd0, 5'd2, 1'b1, 32'd8, 1'b0, 32'd0);
        rs_wb(4'd0, 32'd0);
        tick();
        checks++; if ({roll_back, rb_pc_out} !== {1'b1, 32'h100}) begin errors++; $display("FAIL mp_rollback got=%b/%h exp=1/100", roll_back, rb_pc_out); end
        checks++; if ({rf_commit_en, rob_tail_idx_out, rob_full} !== {1'b0, 4'd0, 1'b0}) begin errors++; $display("FAIL mp_flush got=%b/%0d/%b exp=0/0/0", rf_commit_en, rob_tail_idx_out, rob_full); end
        alloc(2'd0, 5'd9, 1'b1, 32'h9, 1'b0, 32'd0);
        checks++; if ({roll_back, rob_tail_idx_out} !== {1'b0, 4'd0}) begin errors++; $display("FAIL mp_noalloc got=%b/%0d exp=0/0", roll_back, rob_tail_idx_out); end
        tick();
        tick();
        checks++; if (rf_commit_en !== 1'b0) begin errors++; $display("FAIL mp_younger got=%b exp=0", rf_commit_en); end
        alloc(2'd0, 5'd3, 1'b1, 32'h33, 1'b0, 32'd0);
        tick();
        checks++; if ({rf_commit_en, rf_commit_rob_idx, rf_commit_val} !== {1'b1, 4'd0, 32'h33}) begin errors++; $display("FAIL mp_restart got=%b/%0d/%h exp=1/0/33", rf_commit_en, rf_commit_rob_idx, rf_commit_val); end
    endtask

    task automatic test_branch_ok();
        do_reset();
        alloc(2'd1, 5'd0, 1'b1, 32'd0, 1'b0, 32'h200);
        alloc(2'd0, 5'd4, 1'b1, 32'h44, 1'b0, 32'd0);
        checks++; if ({roll_back, rf_commit_en} !== 2'b00) begin errors++; $display("FAIL br_silent got=%b%b exp=00", roll_back, rf_commit_en); end
        tick();
        checks++; if ({rf_commit_en, rf_commit_rob_idx, roll_back} !== {1'b1, 4'd1, 1'b0}) begin errors++; $display("FAIL br_next got=%b/%0d/%b exp=1/1/0", rf_commit_en, rf_commit_rob_idx, roll_back); end
    endtask

    task automatic test_stall();
        do_reset();
        alloc(2'd0, 5'd9, 1'b1, 32'h99, 1'b0, 32'd0);
        rdy_in = 1'b0;
        de_in_en = 1'b1;
        tick();
        checks++; if (rf_commit_en !== 1'b0) begin errors++; $display("FAIL stall_c1 got=%b exp=0", rf_commit_en); end
        tick();
        checks++; if ({rf_commit_en, rob_tail_idx_out} !== {1'b0, 4'd1}) begin errors++; $display("FAIL stall_c2 got=%b/%0d exp=0/1", rf_commit_en, rob_tail_idx_out); end
        rdy_in = 1'b1;
        de_in_en = 1'b0;
        tick();
        checks++; if ({rf_commit_en, rf_commit_val} !== {1'b1, 32'h99}) begin errors++; $display("FAIL stall_resume got=%b/%h exp=1/99", rf_commit_en, rf_commit_val); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        alloc(2'd0, 5'd6, 1'b1, 32'h66, 1'b0, 32'd0);
        #2 rst_in = 1'b0;
        #1;
        checks++; if ({rob_tail_idx_out, rob_full} !== {4'd0, 1'b0}) begin errors++; $display("FAIL mreset_async got=%0d/%b exp=0/0", rob_tail_idx_out, rob_full); end
        tick();
        rst_in = 1'b1;
        tick();
        tick();
        checks++; if (rf_commit_en !== 1'b0) begin errors++; $display("FAIL mreset_nocommit got=%b exp=0", rf_commit_en); end
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_full_wrap();
        test_ooo();
        test_store();
        test_lookup_collision();
        test_mispredict();
        test_branch_ok();
        test_stall();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
